// File: rtl/switch_pkg.sv
// Shared types and constants for the multicast packet switch.
// Optional statistics are enabled by defining SWITCH_STATS_EN.
package switch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      DROP    = 2'd2
   } sw_state_e;

   localparam logic [7:0] REG_EN_MASK        = 8'h10;
   localparam logic [7:0] REG_DROP_CNT       = 8'h11;
   localparam logic [7:0] REG_PKT_CNT_BASE   = 8'h20;
   localparam logic [7:0] DEFAULT_BCAST_ADDR = 8'hFF;

endpackage

// File: rtl/switch_if.sv
// Ingress stream, egress ports and register bus of the switch in one bundle.
// slave: seen from the switch; master: seen from the surrounding environment.
interface switch_if #(
   parameter int N  = 4,
   parameter int WW = 8
);
   logic            sw_enable_in;
   logic [WW-1:0]   data_in;
   logic            data_last_in;
   logic            read_out;
   logic [N*WW-1:0] port_out;
   logic [N-1:0]    port_last;
   logic [N-1:0]    port_ready;
   logic [N-1:0]    port_read;
   logic            mem_sel_en;
   logic            mem_wr_rd_s;
   logic [7:0]      mem_addr;
   logic [WW-1:0]   mem_wr_data;
   logic [WW-1:0]   mem_rd_data;
   logic            mem_ack;

   modport slave (
      input  sw_enable_in, data_in, data_last_in, port_read,
      input  mem_sel_en, mem_wr_rd_s, mem_addr, mem_wr_data,
      output read_out, port_out, port_last, port_ready,
      output mem_rd_data, mem_ack
   );

   modport master (
      output sw_enable_in, data_in, data_last_in, port_read,
      output mem_sel_en, mem_wr_rd_s, mem_addr, mem_wr_data,
      input  read_out, port_out, port_last, port_ready,
      input  mem_rd_data, mem_ack
   );
endinterface

// File: rtl/switch_fifo.sv
// First-word-fall-through synchronous FIFO for one egress port.
// Full/empty come straight from the occupancy register, so a pop never
// frees a slot for a push in the same cycle.
module switch_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push_s, do_pop_s;

   assign full      = (count_q == (AW+1)'(DEPTH));
   assign empty     = (count_q == '0);
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;
   // Head word is forced to zero while empty so stale storage never shows.
   assign dout      = empty ? '0 : mem_q[rd_ptr_q];

   // Pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset flushes the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; contents need no reset because the head is gated by empty.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/switch_mc_top.sv
// Multicast packet switch: copies each framed input packet into the FIFOs of
// every enabled port whose address matches the destination (or broadcast),
// drops unmatched packets, and exposes a small register file.
// Optional feature macro: SWITCH_STATS_EN (drop and per-port packet counters).
module switch_mc_top
   import switch_pkg::*;
#(
   parameter int         NUM_OF_PORTS = 4,
   parameter int         FIFO_SIZE    = 16,
   parameter int         WORD_WIDTH   = 8,
   parameter logic [7:0] BCAST_ADDR   = DEFAULT_BCAST_ADDR
) (
   input  logic    clk,
   input  logic    rst,
   switch_if.slave bus
);
   localparam int N  = NUM_OF_PORTS;
   localparam int WW = WORD_WIDTH;

   sw_state_e       state_q, state_d;
   logic [N-1:0]    tgt_q, tgt_d;
   logic [N-1:0]    match_s, push_s, full_s, empty_s;
   logic [7:0]      da_s;
   logic            read_s, go_s, hdr_accept_s, drop_inc_s;

   logic [7:0]      addr_q [N];
   logic [7:0]      addr_d [N];
   logic [N-1:0]    en_mask_q, en_mask_d;
   logic            mem_ack_q, mem_ack_d;
   logic [WW-1:0]   mem_rd_data_q, mem_rd_data_d, rd_val_s;
   logic            take_s, wr_take_s;
   logic [WW-1:0]   drop_cnt_s;
   logic [WW-1:0]   pkt_cnt_s [N];

   assign da_s         = bus.data_in[7:0];
   assign bus.read_out = read_s & ~rst;
   assign take_s       = bus.mem_sel_en & ~mem_ack_q;
   assign wr_take_s    = take_s & bus.mem_wr_rd_s;
   assign bus.mem_ack     = mem_ack_q;
   assign bus.mem_rd_data = mem_rd_data_q;

   // Target decode of the word on data_in, using the live config registers.
   always_comb begin
      match_s = '0;
      for (int i = 0; i < N; i++) begin
         match_s[i] = en_mask_q[i] & ((addr_q[i] == da_s) | (da_s == BCAST_ADDR));
      end
   end

   // Packet FSM next-state, input ready and FIFO push fan-out.
   always_comb begin
      state_d      = state_q;
      tgt_d        = tgt_q;
      push_s       = '0;
      read_s       = 1'b0;
      go_s         = 1'b0;
      hdr_accept_s = 1'b0;
      drop_inc_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (match_s == '0) begin
               read_s = 1'b1;
            end else begin
               read_s = &(~full_s | ~match_s);
            end
            go_s = bus.sw_enable_in & read_s & ~rst;
            if (go_s) begin
               if (match_s == '0) begin
                  drop_inc_s = 1'b1;
                  if (bus.data_last_in) begin
                     state_d = IDLE;
                  end else begin
                     state_d = DROP;
                  end
               end else begin
                  push_s       = match_s;
                  tgt_d        = match_s;
                  hdr_accept_s = 1'b1;
                  if (bus.data_last_in) begin
                     state_d = IDLE;
                  end else begin
                     state_d = PAYLOAD;
                  end
               end
            end else begin
               state_d = IDLE;
            end
         end
         PAYLOAD: begin
            read_s = &(~full_s | ~tgt_q);
            go_s   = bus.sw_enable_in & read_s & ~rst;
            if (go_s) begin
               push_s = tgt_q;
               if (bus.data_last_in) begin
                  state_d = IDLE;
               end else begin
                  state_d = PAYLOAD;
               end
            end else begin
               state_d = PAYLOAD;
            end
         end
         DROP: begin
            read_s = 1'b1;
            go_s   = bus.sw_enable_in & ~rst;
            if (go_s && bus.data_last_in) begin
               state_d = IDLE;
            end else begin
               state_d = DROP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state and latched target set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
      end
   end

   // Register read mux; unmapped offsets OR in nothing and so read 0.
   always_comb begin
      rd_val_s = '0;
      rd_val_s = rd_val_s | ((bus.mem_addr == REG_EN_MASK)  ? WW'(en_mask_q) : '0);
      rd_val_s = rd_val_s | ((bus.mem_addr == REG_DROP_CNT) ? drop_cnt_s     : '0);
      for (int i = 0; i < N; i++) begin
         rd_val_s = rd_val_s | ((bus.mem_addr == 8'(i)) ? WW'(addr_q[i]) : '0);
         rd_val_s = rd_val_s | ((bus.mem_addr == (REG_PKT_CNT_BASE + 8'(i))) ? pkt_cnt_s[i] : '0);
      end
   end

   // Register bus next-state: one access per ack, writes land with the ack.
   always_comb begin
      mem_ack_d = take_s;
      if (take_s && !bus.mem_wr_rd_s) begin
         mem_rd_data_d = rd_val_s;
      end else begin
         mem_rd_data_d = '0;
      end
      for (int i = 0; i < N; i++) begin
         addr_d[i] = (wr_take_s && (bus.mem_addr == 8'(i))) ? bus.mem_wr_data[7:0] : addr_q[i];
      end
      if (wr_take_s && (bus.mem_addr == REG_EN_MASK)) begin
         en_mask_d = bus.mem_wr_data[N-1:0];
      end else begin
         en_mask_d = en_mask_q;
      end
   end

   // Config registers and bus response flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            addr_q[i] <= 8'(i);
         end
         en_mask_q     <= '1;
         mem_ack_q     <= 1'b0;
         mem_rd_data_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            addr_q[i] <= addr_d[i];
         end
         en_mask_q     <= en_mask_d;
         mem_ack_q     <= mem_ack_d;
         mem_rd_data_q <= mem_rd_data_d;
      end
   end

`ifdef SWITCH_STATS_EN
   logic [WW-1:0] drop_cnt_q, drop_cnt_d;
   logic [WW-1:0] pkt_cnt_q [N];
   logic [WW-1:0] pkt_cnt_d [N];
   logic          cnt_clr_s;

   assign cnt_clr_s  = wr_take_s & (bus.mem_addr == REG_DROP_CNT);
   assign drop_cnt_s = drop_cnt_q;
   assign pkt_cnt_s  = pkt_cnt_q;

   // Saturating counters; a write to the drop counter clears them all.
   always_comb begin
      if (cnt_clr_s) begin
         drop_cnt_d = '0;
      end else if (drop_inc_s && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + WW'(1);
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
      for (int i = 0; i < N; i++) begin
         if (cnt_clr_s) begin
            pkt_cnt_d[i] = '0;
         end else if (hdr_accept_s && match_s[i] && (pkt_cnt_q[i] != '1)) begin
            pkt_cnt_d[i] = pkt_cnt_q[i] + WW'(1);
         end else begin
            pkt_cnt_d[i] = pkt_cnt_q[i];
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt_q <= '0;
         for (int i = 0; i < N; i++) begin
            pkt_cnt_q[i] <= '0;
         end
      end else begin
         drop_cnt_q <= drop_cnt_d;
         for (int i = 0; i < N; i++) begin
            pkt_cnt_q[i] <= pkt_cnt_d[i];
         end
      end
   end
`else
   logic stats_unused_s;

   assign stats_unused_s = drop_inc_s ^ hdr_accept_s;
   assign drop_cnt_s     = '0;
   for (genvar g = 0; g < N; g++) begin : g_no_cnt
      assign pkt_cnt_s[g] = '0;
   end
`endif

   // One FIFO per egress port; each entry carries {last, data}.
   for (genvar g = 0; g < N; g++) begin : g_port
      logic [WW:0] dout_s;

      switch_fifo #(
         .DEPTH (FIFO_SIZE),
         .WIDTH (WW + 1)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push_s[g]),
         .din   ({bus.data_last_in, bus.data_in}),
         .pop   (bus.port_read[g]),
         .dout  (dout_s),
         .full  (full_s[g]),
         .empty (empty_s[g])
      );

      assign bus.port_out[g*WW +: WW] = dout_s[WW-1:0];
      assign bus.port_last[g]         = dout_s[WW];
      assign bus.port_ready[g]        = ~empty_s[g];
   end

endmodule

// File: tb/tb_switch_mc_top.sv
// Directed bench for switch_mc_top with a per-port expected-word scoreboard.
module tb_switch_mc_top;
   import switch_pkg::*;

   localparam int N  = 4;
   localparam int WW = 8;
`ifdef SWITCH_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   switch_if #(.N(N), .WW(WW)) bus ();

   switch_mc_top #(
      .NUM_OF_PORTS (N),
      .FIFO_SIZE    (16),
      .WORD_WIDTH   (WW),
      .BCAST_ADDR   (8'hFF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   logic [8:0]   exp_q [N][$];
   logic [N-1:0] drain_en = '0;
   int           pop_req  [N];
   int           pop_done [N];
   int           popped   [N];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Egress consumer: pops enabled ports and compares heads with the scoreboard.
   initial begin
      bus.port_read = '0;
      for (int i = 0; i < N; i++) begin
         pop_req[i]  = 0;
         pop_done[i] = 0;
         popped[i]   = 0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (bus.port_ready[i] && (drain_en[i] || (pop_req[i] > pop_done[i]))) begin
               if (exp_q[i].size() == 0) begin
                  check($sformatf("unexpected_word_p%0d", i), 32'd1, 32'd0);
               end else begin
                  check($sformatf("word_p%0d", i),
                        {bus.port_last[i], bus.port_out[i*WW +: WW]}, exp_q[i].pop_front());
               end
               popped[i]++;
               if (!drain_en[i]) pop_done[i]++;
               bus.port_read[i] = 1'b1;
            end else begin
               bus.port_read[i] = 1'b0;
            end
         end
      end
   end

   task automatic send_word(input logic [7:0] d, input logic last, input logic [N-1:0] tgt);
      int n;
      bus.sw_enable_in = 1'b1;
      bus.data_in      = d;
      bus.data_last_in = last;
      #1;
      n = 0;
      while (!bus.read_out && n < 300) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (n >= 300) begin
         check("send_timeout", 32'd0, 32'd1);
      end else begin
         for (int i = 0; i < N; i++) begin
            if (tgt[i]) exp_q[i].push_back({last, d});
         end
      end
      @(posedge clk);
      #1;
      bus.sw_enable_in = 1'b0;
      bus.data_last_in = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] da, input int len, input logic [7:0] seed,
                           input logic [N-1:0] tgt);
      send_word(da, (len == 1), tgt);
      for (int k = 1; k < len; k++) begin
         send_word(seed + 8'(k), (k == len - 1), tgt);
      end
   endtask

   task automatic wait_drain(input string tag);
      int n;
      int left;
      n = 0;
      left = 1;
      while (left != 0 && n < 500) begin
         left = 0;
         for (int i = 0; i < N; i++) left += exp_q[i].size();
         @(posedge clk);
         n++;
      end
      check(tag, 32'(left), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
      bus.mem_sel_en  = 1'b1;
      bus.mem_wr_rd_s = 1'b1;
      bus.mem_addr    = a;
      bus.mem_wr_data = d;
      @(posedge clk);
      #1;
      check("wr_ack", 32'(bus.mem_ack), 32'd1);
      bus.mem_sel_en  = 1'b0;
      bus.mem_wr_rd_s = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic reg_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
      bus.mem_sel_en  = 1'b1;
      bus.mem_wr_rd_s = 1'b0;
      bus.mem_addr    = a;
      @(posedge clk);
      #1;
      check({tag, "_ack"}, 32'(bus.mem_ack), 32'd1);
      check(tag, 32'(bus.mem_rd_data), 32'(exp));
      bus.mem_sel_en = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_idle"}, 32'(bus.mem_rd_data), 32'd0);
   endtask

   task automatic clear_popped();
      for (int i = 0; i < N; i++) popped[i] = 0;
   endtask

   // Directed sequence.
   initial begin
      rst              = 1'b1;
      bus.sw_enable_in = 1'b0;
      bus.data_in      = '0;
      bus.data_last_in = 1'b0;
      bus.mem_sel_en   = 1'b0;
      bus.mem_wr_rd_s  = 1'b0;
      bus.mem_addr     = '0;
      bus.mem_wr_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_read_out",   32'(bus.read_out),   32'd0);
      check("rst_port_ready", 32'(bus.port_ready), 32'd0);
      check("rst_port_out",   32'(bus.port_out),   32'd0);
      check("rst_port_last",  32'(bus.port_last),  32'd0);
      check("rst_mem_ack",    32'(bus.mem_ack),    32'd0);
      check("rst_rd_data",    32'(bus.mem_rd_data), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: defaults and unicast to port 2
      reg_read(8'h00, 8'h00, "addr0_dflt");
      reg_read(8'h03, 8'h03, "addr3_dflt");
      reg_read(REG_EN_MASK, 8'h0F, "en_dflt");
      reg_read(8'h30, 8'h00, "unmapped_rd");
      drain_en = 4'b1111;
      clear_popped();
      send_pkt(8'h02, 3, 8'hD0, 4'b0100);
      wait_drain("t1_drain");
      check("t1_p2_cnt",   32'(popped[2]), 32'd3);
      check("t1_p0_cnt",   32'(popped[0]), 32'd0);
      reg_read(REG_PKT_CNT_BASE + 8'd2, 8'(STATS), "t1_pkt_cnt2");

      // 2: broadcast with port 2 masked off
      reg_write(REG_EN_MASK, 8'h0B);
      drain_en = 4'b1011;
      clear_popped();
      send_pkt(8'hFF, 3, 8'hB0, 4'b1011);
      wait_drain("t2_drain");
      check("t2_p2_ready", 32'(bus.port_ready[2]), 32'd0);
      check("t2_p0_cnt",   32'(popped[0]), 32'd3);
      check("t2_p3_cnt",   32'(popped[3]), 32'd3);
      reg_write(REG_EN_MASK, 8'h0F);
      drain_en = 4'b1111;

      // 3: no-match drop
      for (int k = 0; k < 4; k++) begin
         bus.sw_enable_in = 1'b1;
         bus.data_in      = (k == 0) ? 8'h55 : 8'(8'h60 + k);
         bus.data_last_in = (k == 3);
         #1;
         check("t3_drop_ready", 32'(bus.read_out), 32'd1);
         send_word(bus.data_in, (k == 3), 4'b0000);
      end
      @(posedge clk);
      #1;
      check("t3_no_push", 32'(bus.port_ready), 32'd0);
      reg_read(REG_DROP_CNT, 8'(STATS), "t3_drop_cnt");

      // 4: backpressure on a two-port multicast
      reg_write(8'h01, 8'h07);
      reg_write(8'h03, 8'h07);
      drain_en = 4'b0000;
      clear_popped();
      for (int k = 0; k < 16; k++) begin
         send_word((k == 0) ? 8'h07 : 8'(8'h40 + k), 1'b0, 4'b1010);
      end
      bus.sw_enable_in = 1'b1;
      bus.data_in      = 8'h50;
      bus.data_last_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("t4_full_stall", 32'(bus.read_out), 32'd0);
      pop_req[1]++;
      repeat (4) @(posedge clk);
      #1;
      check("t4_one_pop",    32'(popped[1]), 32'd1);
      check("t4_no_resume",  32'(bus.read_out), 32'd0);
      drain_en = 4'b1010;
      for (int k = 16; k < 20; k++) begin
         send_word(8'(8'h40 + k), (k == 19), 4'b1010);
      end
      wait_drain("t4_drain");
      check("t4_p1_cnt", 32'(popped[1]), 32'd20);
      check("t4_p3_cnt", 32'(popped[3]), 32'd20);
      drain_en = 4'b1111;

      // 5: address change during an in-flight packet
      clear_popped();
      send_word(8'h00, 1'b0, 4'b0001);
      send_word(8'hA1, 1'b0, 4'b0001);
      reg_write(8'h00, 8'h09);
      send_word(8'hA2, 1'b0, 4'b0001);
      send_word(8'hA3, 1'b1, 4'b0001);
      send_pkt(8'h09, 2, 8'hC0, 4'b0001);
      wait_drain("t5_drain");
      check("t5_p0_cnt", 32'(popped[0]), 32'd6);
      reg_read(8'h00, 8'h09, "t5_addr0");

      // 6: reset in the middle of a packet
      drain_en = 4'b0000;
      send_word(8'h02, 1'b0, 4'b0100);
      send_word(8'h61, 1'b0, 4'b0100);
      @(posedge clk);
      #1;
      check("t6_pre_ready", 32'(bus.port_ready), 32'h4);
      bus.sw_enable_in = 1'b1;
      bus.data_in      = 8'h62;
      rst = 1'b1;
      #1;
      check("t6_rst_ready",    32'(bus.port_ready), 32'd0);
      check("t6_rst_read_out", 32'(bus.read_out),   32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("t6_rst_hold", 32'(bus.read_out), 32'd0);
      for (int i = 0; i < N; i++) exp_q[i].delete();
      bus.sw_enable_in = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      reg_read(8'h00, 8'h00, "t6_addr0");
      reg_read(8'h01, 8'h01, "t6_addr1");
      reg_read(REG_EN_MASK, 8'h0F, "t6_en");
      reg_read(REG_PKT_CNT_BASE + 8'd2, 8'h00, "t6_pkt_cnt2");
      drain_en = 4'b1111;
      clear_popped();
      send_pkt(8'h01, 3, 8'hE0, 4'b0010);
      wait_drain("t6_drain");
      check("t6_p1_cnt", 32'(popped[1]), 32'd3);
      check("t6_p2_cnt", 32'(popped[2]), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
